icache_data_bank_ctrl: RTL and testbench
========================================

# icache_data_bank_ctrl

Parametrised I-cache data-array controller: arbitrates hit reads against MSHR linefill writes into a WAY_NUM-way, BANK_NUM-banked data array, returns read data (and optionally forwarded linefill data) to upstream through a credit-protected response FIFO with full valid/ready backpressure. It sits between the tag/MSHR pipeline and the upstream fetch port, and replaces the fixed 2-way, 2-bank, no-backpressure controller.

## Interface
- WAY_NUM, 4, ways per set (power of 2, ≥2)
- BANK_NUM, 2, data banks per line (power of 2; LINE_WIDTH divisible)
- INDEX_WIDTH, ICACHE_INDEX_WIDTH, set index width
- LINE_WIDTH, ICACHE_DATA_WIDTH, cacheline bits
- TXNID_WIDTH, ICACHE_REQ_TXNID_WIDTH, transaction id width
- ENTRY_NUM, MSHR_ENTRY_NUM, MSHR entries
- RSP_DEPTH, 4, response FIFO depth (≥2)
- STARVE_MAX, 3, consecutive linefill grants before a waiting read is forced
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_vld / rd_rdy  in/out  1  hit-read handshake
- rd_way  in  $clog2(WAY_NUM)  way to read
- rd_index  in  INDEX_WIDTH  set to read
- rd_txnid  in  TXNID_WIDTH  request id
- lf_vld / lf_rdy  in/out  1  linefill handshake from downstream rxdat
- lf_pld  in  lf_pld_t  {entry_idx, txnid, fwd (opcode==UPSTREAM_OPCODE), data}
- mshr_index  in  ENTRY_NUM×INDEX_WIDTH  per-entry set index
- mshr_way  in  ENTRY_NUM×$clog2(WAY_NUM)  per-entry destination way
- lf_done  out  1  one-cycle pulse per accepted linefill
- lf_ack_entry_idx  out  $clog2(ENTRY_NUM)  entry of lf_done
- up_vld / up_rdy  out/in  1  upstream data handshake
- up_data  out  LINE_WIDTH  line data
- up_txnid  out  TXNID_WIDTH  response id

## Operation
- Array address = {index, way}; each bank is LINE_WIDTH/BANK_NUM wide; bank b holds data[(b+1)*W-1 : b*W]; all banks share address/enable.
- Credit: credit_ok = (rsp_cnt + inflight) < RSP_DEPTH, inflight = read issued last cycle. Freed entries return credit the cycle after the pop.
- Eligibility: read needs credit_ok; linefill with fwd=1 needs credit_ok; fwd=0 linefill needs none.
- Arbitration (one array op per cycle): linefill wins by default; if rd_vld is pending and starve_cnt == STARVE_MAX, read wins. starve_cnt increments on each linefill grant while rd_vld=1 and read eligible; clears on read grant or rd_vld=0; saturates.
- rd_rdy / lf_rdy are combinational grants (no valid→ready dependency on the same port's own valid beyond arbitration).
- Linefill grant: write all banks at {mshr_index[e], mshr_way[e]}, pulse lf_done with entry_idx same cycle; if fwd=1, push {data, txnid} into FIFO next cycle.
- Read grant: array read; next cycle push {bank douts concatenated, txnid} into FIFO.
- At most one push per cycle by construction. FIFO output drives up_*; pop on up_vld && up_rdy. Order = grant order.

## Timing
- Reset: rd_rdy, lf_rdy, lf_done, up_vld = 0; lf_ack_entry_idx, up_data, up_txnid = 0; FIFO empty, starve_cnt=0, inflight=0.
- Read granted cycle N → FIFO push end of N+1 → up_vld earliest N+2.
- Forwarding linefill granted N → up_vld earliest N+2.
- Full FIFO: rd_rdy=0 and fwd linefill lf_rdy=0; non-fwd linefill still accepted.
- Simultaneous push and pop on a full FIFO is legal; no data loss, count unchanged.
- Reset mid-operation discards FIFO contents and in-flight read; array contents undefined-preserving (not cleared).
- Pointers wrap modulo RSP_DEPTH; rsp_cnt width $clog2(RSP_DEPTH+1).

## Structure
- Package toy_pack: lf_pld_t, UPSTREAM_OPCODE, default width constants.
- Sub-modules: toy_mem_model_bit per bank (generate loop); icache_rsp_fifo (parametric sync FIFO, count output).

## Test plan
- Single read way 3 index 0x10 after linefill of entry 2 (index 0x10, way 3, data 0xA5..) → up_data matches at N+2, txnid echoed, lf_done pulse at grant cycle with idx 2.
- Continuous lf_vld with rd_vld held, STARVE_MAX=3 → read granted on 4th cycle; starve_cnt clears.
- up_rdy=0, RSP_DEPTH=4 → exactly 4 reads accepted, rd_rdy low thereafter; non-fwd linefill still accepted; release up_rdy → 4 in-order responses.
- fwd=1 linefill txnid 0x5 with FIFO full → lf_rdy=0 until a pop, then accepted; up returns data with txnid 0x5.
- Full FIFO with concurrent pop and read grant → count stays 4, no drop/duplicate.
- Assert rst_n low with 2 entries queued and a read in flight → up_vld=0 next cycle, no stale response after release.

Source files
------------

// File: rtl/icache_data_bank_ctrl_pkg.sv
// toy_pack: shared widths, opcode constant and linefill payload type for the I-cache data bank controller
package toy_pack;
  localparam int ICACHE_INDEX_WIDTH     = 6;
  localparam int ICACHE_DATA_WIDTH      = 64;
  localparam int ICACHE_REQ_TXNID_WIDTH = 4;
  localparam int MSHR_ENTRY_NUM         = 4;
  localparam int ENTRY_IDX_WIDTH        = $clog2(MSHR_ENTRY_NUM);
  localparam logic [3:0] UPSTREAM_OPCODE = 4'h5;
  typedef struct packed {
    logic [ENTRY_IDX_WIDTH-1:0]        entry_idx;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
    logic                              fwd;
    logic [ICACHE_DATA_WIDTH-1:0]      data;
  } lf_pld_t;
endpackage

// File: rtl/icache_data_bank_ctrl_fifo.sv
// icache_rsp_fifo: synchronous response FIFO with occupancy count, push allowed on full when popping
module icache_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic pop_ok, push_ok;
  assign pop_ok  = pop_i && cnt_q != '0;
  assign push_ok = push_i && (cnt_q != CW'(DEPTH) || pop_ok);
  // storage and pointers, cleared on reset so outputs read zero
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) mem_q[wr_q] <= din_i;
      if (push_ok) wr_q <= wr_q == AW'(DEPTH-1) ? '0 : wr_q + 1'b1;
      if (pop_ok) rd_q <= rd_q == AW'(DEPTH-1) ? '0 : rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/icache_data_bank_ctrl_mem.sv
// toy_mem_model_bit: single-port synchronous data bank, contents survive reset
module toy_mem_model_bit #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0] dout_o
);
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] dout_q;
  // write port
  always_ff @(posedge clk)
    if (en_i && we_i) mem_q[addr_i] <= din_i;
  // read data held until the next read so a later write cannot disturb it
  always_ff @(posedge clk)
    if (en_i && !we_i) dout_q <= mem_q[addr_i];
  assign dout_o = dout_q;
endmodule

// File: rtl/icache_data_bank_ctrl.sv
// icache_data_bank_ctrl: arbitrates hit reads and linefill writes into a banked data array, returns data via a credited FIFO
module icache_data_bank_ctrl
  import toy_pack::*;
#(
  parameter int WAY_NUM     = 4,
  parameter int BANK_NUM    = 2,
  parameter int INDEX_WIDTH = ICACHE_INDEX_WIDTH,
  parameter int LINE_WIDTH  = ICACHE_DATA_WIDTH,
  parameter int TXNID_WIDTH = ICACHE_REQ_TXNID_WIDTH,
  parameter int ENTRY_NUM   = MSHR_ENTRY_NUM,
  parameter int RSP_DEPTH   = 4,
  parameter int STARVE_MAX  = 3
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           rd_vld,
  output logic                                           rd_rdy,
  input  logic [$clog2(WAY_NUM)-1:0]                     rd_way,
  input  logic [INDEX_WIDTH-1:0]                         rd_index,
  input  logic [TXNID_WIDTH-1:0]                         rd_txnid,
  input  logic                                           lf_vld,
  output logic                                           lf_rdy,
  input  lf_pld_t                                        lf_pld,
  input  logic [ENTRY_NUM-1:0][INDEX_WIDTH-1:0]          mshr_index,
  input  logic [ENTRY_NUM-1:0][$clog2(WAY_NUM)-1:0]      mshr_way,
  output logic                                           lf_done,
  output logic [$clog2(ENTRY_NUM)-1:0]                   lf_ack_entry_idx,
  output logic                                           up_vld,
  input  logic                                           up_rdy,
  output logic [LINE_WIDTH-1:0]                          up_data,
  output logic [TXNID_WIDTH-1:0]                         up_txnid
);
  localparam int WW = $clog2(WAY_NUM);
  localparam int EW = $clog2(ENTRY_NUM);
  localparam int BW = LINE_WIDTH / BANK_NUM;
  localparam int AW = INDEX_WIDTH + WW;
  localparam int CW = $clog2(RSP_DEPTH+1);
  localparam int SW = $clog2(STARVE_MAX+1);
  logic run_q, push_rd_q, push_lf_q;
  logic [LINE_WIDTH-1:0] fwd_data_q, rd_line, fifo_data;
  logic [TXNID_WIDTH-1:0] push_txn_q, fifo_txn;
  logic [SW-1:0] starve_q, starve_d;
  logic [CW-1:0] rsp_cnt;
  logic [EW-1:0] lf_ent;
  logic credit_ok, rd_elig, force_rd, lf_gnt, rd_gnt;
  logic [AW-1:0] arr_addr;
  assign lf_ent = EW'(lf_pld.entry_idx);
  // a pending push (read or forwarded linefill) counts as occupied until it lands
  always_comb begin
    credit_ok = run_q && (32'(rsp_cnt) + 32'(push_rd_q || push_lf_q)) < RSP_DEPTH;
    rd_elig   = rd_vld && credit_ok;
    force_rd  = rd_elig && starve_q == SW'(STARVE_MAX);
    lf_rdy    = run_q && (!lf_pld.fwd || credit_ok) && !force_rd;
    lf_gnt    = lf_vld && lf_rdy;
    rd_rdy    = credit_ok && !lf_gnt;
    rd_gnt    = rd_vld && rd_rdy;
    starve_d  = (!rd_vld || rd_gnt) ? '0 :
                (lf_gnt && rd_elig && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
    arr_addr  = lf_gnt ? {mshr_index[lf_ent], mshr_way[lf_ent]} : {rd_index, rd_way};
  end
  // grant bookkeeping: push is scheduled for the cycle after the grant
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      run_q      <= 1'b0;
      push_rd_q  <= 1'b0;
      push_lf_q  <= 1'b0;
      push_txn_q <= '0;
      fwd_data_q <= '0;
      starve_q   <= '0;
    end else begin
      run_q      <= 1'b1;
      push_rd_q  <= rd_gnt;
      push_lf_q  <= lf_gnt && lf_pld.fwd;
      push_txn_q <= rd_gnt ? rd_txnid : lf_pld.txnid;
      fwd_data_q <= lf_pld.data;
      starve_q   <= starve_d;
    end
  for (genvar b = 0; b < BANK_NUM; b++) begin : g_bank
    toy_mem_model_bit #(.ADDR_WIDTH(AW), .DATA_WIDTH(BW)) u_bank (
      .clk    (clk),
      .en_i   (lf_gnt || rd_gnt),
      .we_i   (lf_gnt),
      .addr_i (arr_addr),
      .din_i  (lf_pld.data[b*BW +: BW]),
      .dout_o (rd_line[b*BW +: BW])
    );
  end
  icache_rsp_fifo #(.DEPTH(RSP_DEPTH), .WIDTH(LINE_WIDTH+TXNID_WIDTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_rd_q || push_lf_q),
    .din_i   ({push_rd_q ? rd_line : fwd_data_q, push_txn_q}),
    .pop_i   (up_vld && up_rdy),
    .dout_o  ({fifo_data, fifo_txn}),
    .count_o (rsp_cnt)
  );
  assign lf_done          = lf_gnt;
  assign lf_ack_entry_idx = lf_gnt ? lf_ent : '0;
  assign up_vld           = rsp_cnt != '0;
  assign up_data          = fifo_data;
  assign up_txnid         = fifo_txn;
endmodule

// File: tb/tb_icache_data_bank_ctrl.sv
// tb_icache_data_bank_ctrl: directed and random stimulus checked against a transaction-level model
module tb_icache_data_bank_ctrl;
  import toy_pack::*;
  localparam int WN = 4, IW = ICACHE_INDEX_WIDTH, LW = ICACHE_DATA_WIDTH, TW = ICACHE_REQ_TXNID_WIDTH;
  localparam int EN = MSHR_ENTRY_NUM, RD = 4, SM = 3;
  typedef struct { logic [LW-1:0] d; logic [TW-1:0] t; int c; } rsp_t;
  logic clk = 0, rst_n = 0;
  logic rd_vld = 0, rd_rdy, lf_vld = 0, lf_rdy, lf_done, up_vld, up_rdy = 0;
  logic [1:0] rd_way = 0;
  logic [IW-1:0] rd_index = 0;
  logic [TW-1:0] rd_txnid = 0, up_txnid;
  lf_pld_t lf_pld = '0;
  logic [EN-1:0][IW-1:0] mshr_index = '0;
  logic [EN-1:0][1:0] mshr_way = '0;
  logic [1:0] lf_ack_entry_idx;
  logic [LW-1:0] up_data;
  logic [LW-1:0] mem [2**IW][WN];
  rsp_t q[$];
  int checks = 0, failures = 0, outst = 0, starve = 0, cyc = 0;
  bit m_rg, m_lg, o_rg;
  icache_data_bank_ctrl #(.WAY_NUM(WN), .BANK_NUM(2), .INDEX_WIDTH(IW), .LINE_WIDTH(LW), .TXNID_WIDTH(TW),
    .ENTRY_NUM(EN), .RSP_DEPTH(RD), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n), .rd_vld(rd_vld), .rd_rdy(rd_rdy), .rd_way(rd_way), .rd_index(rd_index),
    .rd_txnid(rd_txnid), .lf_vld(lf_vld), .lf_rdy(lf_rdy), .lf_pld(lf_pld), .mshr_index(mshr_index),
    .mshr_way(mshr_way), .lf_done(lf_done), .lf_ack_entry_idx(lf_ack_entry_idx), .up_vld(up_vld),
    .up_rdy(up_rdy), .up_data(up_data), .up_txnid(up_txnid));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic reset_checks();
    chk("rst_rd_rdy", rd_rdy, 0);
    chk("rst_lf_rdy", lf_rdy, 0);
    chk("rst_lf_done", lf_done, 0);
    chk("rst_up_vld", up_vld, 0);
    chk("rst_lf_ack", lf_ack_entry_idx, 0);
    chk("rst_up_data", up_data, 0);
    chk("rst_up_txnid", up_txnid, 0);
  endtask
  // one cycle: predict from the rules, compare, then advance the model
  task automatic step();
    bit credit, rel, lel, frc, uv;
    #1;
    credit = outst < RD;
    rel = rd_vld && credit;
    lel = lf_vld && (!lf_pld.fwd || credit);
    frc = rel && starve == SM;
    m_lg = lel && !frc;
    m_rg = rel && !m_lg;
    o_rg = rd_vld && rd_rdy;
    uv = q.size() > 0 && q[0].c <= cyc;
    chk("rd_rdy", rd_rdy, credit && !m_lg);
    chk("lf_rdy", lf_rdy, (!lf_pld.fwd || credit) && !frc);
    chk("lf_done", lf_done, m_lg);
    chk("lf_ack_idx", lf_ack_entry_idx, m_lg ? lf_pld.entry_idx : 0);
    chk("up_vld", up_vld, uv);
    if (uv) begin
      chk("up_data", up_data, q[0].d);
      chk("up_txnid", up_txnid, q[0].t);
    end
    if (m_lg) begin
      mem[mshr_index[lf_pld.entry_idx]][mshr_way[lf_pld.entry_idx]] = lf_pld.data;
      if (lf_pld.fwd) q.push_back('{lf_pld.data, lf_pld.txnid, cyc + 2});
    end
    if (m_rg) q.push_back('{mem[rd_index][rd_way], rd_txnid, cyc + 2});
    outst += int'(m_rg || (m_lg && lf_pld.fwd));
    if (uv && up_rdy) begin
      void'(q.pop_front());
      outst--;
    end
    starve = (!rd_vld || m_rg) ? 0 : (m_lg && rel && starve < SM) ? starve + 1 : starve;
    @(negedge clk);
    cyc++;
  endtask
  task automatic release_reset();
    rst_n = 1;
    @(negedge clk);
    @(negedge clk);
  endtask
  initial begin
    int acc, gc;
    bit got;
    mshr_index = {IW'(3), IW'('h10), IW'(2), IW'(1)};
    mshr_way = {2'd2, 2'd3, 2'd1, 2'd0};
    repeat (2) @(negedge clk);
    #1 reset_checks();
    release_reset();
    // linefill entry 2 then read it back
    lf_vld = 1; lf_pld = '{2'd2, 4'h3, 1'b0, 64'hA5A5_A5A5_A5A5_A5A5};
    step();
    lf_vld = 0; rd_vld = 1; rd_index = 'h10; rd_way = 3; rd_txnid = 4'h7; up_rdy = 1;
    step();
    rd_vld = 0;
    repeat (4) step();
    // starvation: read forced after STARVE_MAX linefill grants
    for (int i = 0; i < 4; i++) begin
      lf_vld = 1; lf_pld = '{2'(i), 4'h1, 1'b0, {$urandom(), $urandom()}};
      step();
    end
    lf_vld = 0;
    gc = -1; rd_vld = 1; rd_index = 1; rd_way = 0; rd_txnid = 4'h9;
    lf_vld = 1; lf_pld = '{2'd1, 4'h2, 1'b0, 64'h1111_2222_3333_4444};
    for (int i = 0; i < 8; i++) begin
      step();
      if (m_rg && gc < 0) begin gc = i; rd_vld = 0; end
    end
    lf_vld = 0;
    chk("starve_gnt_cycle", 64'(gc), 3);
    chk("starve_cleared", 64'(starve), 0);
    repeat (4) step();
    // full FIFO with up_rdy low
    up_rdy = 0; acc = 0; rd_vld = 1;
    for (int i = 0; i < 8; i++) begin
      rd_index = 2; rd_way = 1; rd_txnid = 4'(i);
      step();
      if (o_rg) acc++;
    end
    rd_vld = 0;
    chk("full_accept_cnt", 64'(acc), 4);
    lf_vld = 1; lf_pld = '{2'd0, 4'h4, 1'b0, 64'hDEAD_BEEF_0000_0001};
    #1 chk("nonfwd_on_full", lf_rdy, 1);
    step();
    lf_pld = '{2'd1, 4'h5, 1'b1, 64'h0F0F_0F0F_F0F0_F0F0};
    repeat (2) begin
      #1 chk("fwd_blocked", lf_rdy, 0);
      step();
    end
    up_rdy = 1; got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      step();
      got = m_lg;
    end
    lf_vld = 0;
    chk("fwd_accepted", 64'(got), 1);
    repeat (10) step();
    // full FIFO with concurrent pops and reads
    up_rdy = 0; rd_vld = 1;
    repeat (6) step();
    up_rdy = 1;
    for (int i = 0; i < 10; i++) begin
      rd_index = 'h10; rd_way = 3; rd_txnid = 4'(i + 8);
      step();
    end
    rd_vld = 0;
    repeat (8) step();
    chk("drained_1", 64'(q.size()), 0);
    // reset with two responses queued and a read in flight
    up_rdy = 0; rd_vld = 1;
    repeat (3) step();
    rd_vld = 0; rst_n = 0;
    #1 reset_checks();
    q.delete(); outst = 0; starve = 0;
    @(negedge clk);
    release_reset();
    up_rdy = 1;
    repeat (5) step();
    // random traffic
    for (int i = 0; i < 32; i++) begin
      mshr_index[0] = IW'(i / 4); mshr_way[0] = 2'(i % 4);
      lf_vld = 1; lf_pld = '{2'd0, 4'h0, 1'b0, {$urandom(), $urandom()}};
      step();
    end
    for (int i = 0; i < 400; i++) begin
      for (int e = 0; e < EN; e++) begin
        mshr_index[e] = IW'($urandom_range(0, 7)); mshr_way[e] = 2'($urandom_range(0, 3));
      end
      rd_vld = 1'($urandom_range(0, 1)); rd_index = IW'($urandom_range(0, 7));
      rd_way = 2'($urandom_range(0, 3)); rd_txnid = 4'($urandom_range(0, 15));
      lf_vld = $urandom_range(0, 2) == 0;
      lf_pld = '{2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), {$urandom(), $urandom()}};
      up_rdy = $urandom_range(0, 9) < 7;
      step();
    end
    rd_vld = 0; lf_vld = 0; up_rdy = 1;
    repeat (12) step();
    chk("drained_2", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
